// File: rtl/delay_scheduler.sv
// Blink-delay configuration controller: arbitrates key pulses against Avalon-MM writes,
// saturates the delay, rate-limits keys with a hold-off, and reports status/counters/irq.
module delay_scheduler #(
    parameter int DELAY_WIDTH    = 4,
    parameter int DEFAULT_DELAY  = 8,
    parameter int MIN_DELAY      = 0,
    parameter int MAX_DELAY      = 15,
    parameter int HOLDOFF_CYCLES = 16
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   slower,
    input  logic                   faster,
    input  logic [1:0]             avs_address,
    input  logic                   avs_read,
    input  logic                   avs_write,
    input  logic [31:0]            avs_writedata,
    output logic [31:0]            avs_readdata,
    output logic [DELAY_WIDTH-1:0] delay,
    output logic                   irq
);

    localparam int HOLD_W = (HOLDOFF_CYCLES > 0) ? $clog2(HOLDOFF_CYCLES + 1) : 1;
    localparam logic [DELAY_WIDTH-1:0] MIN_D = DELAY_WIDTH'(MIN_DELAY);
    localparam logic [DELAY_WIDTH-1:0] MAX_D = DELAY_WIDTH'(MAX_DELAY);
    localparam logic [DELAY_WIDTH-1:0] DEF_D = DELAY_WIDTH'(DEFAULT_DELAY);
    localparam logic [31:0]            MIN_W = 32'(MIN_DELAY);
    localparam logic [31:0]            MAX_W = 32'(MAX_DELAY);
    localparam logic [HOLD_W-1:0]      HOLD_LOAD = HOLD_W'(HOLDOFF_CYCLES);

    logic [DELAY_WIDTH-1:0] delay_reg, delay_next;
    logic                   key_en_reg, key_en_next;
    logic                   irq_en_reg, irq_en_next;
    logic [2:0]             status_reg, status_next;
    logic [15:0]            slow_cnt_reg, slow_cnt_next;
    logic [15:0]            fast_cnt_reg, fast_cnt_next;
    logic [HOLD_W-1:0]      hold_reg, hold_next;
    logic [31:0]            rdata_reg, rdata_next;
    logic                   irq_reg, irq_next;

    logic wr_delay, wr_ctrl, wr_status, wr_events;
    logic key_req, key_drop, acc_slow, acc_fast;

    always_comb begin
        wr_delay  = avs_write && (avs_address == 2'd0);
        wr_ctrl   = avs_write && (avs_address == 2'd1);
        wr_status = avs_write && (avs_address == 2'd2);
        wr_events = avs_write && (avs_address == 2'd3);
        // Both keys at once cancel out and never count as a drop.
        key_req   = key_en_reg && (slower ^ faster);
        key_drop  = key_req && (wr_delay || (hold_reg != '0));
        acc_slow  = key_req && !key_drop && slower;
        acc_fast  = key_req && !key_drop && faster;
    end

    always_comb begin
        delay_next    = delay_reg;
        key_en_next   = key_en_reg;
        irq_en_next   = irq_en_reg;
        status_next   = status_reg;
        slow_cnt_next = wr_events ? 16'd0 : slow_cnt_reg;
        fast_cnt_next = wr_events ? 16'd0 : fast_cnt_reg;
        hold_next     = hold_reg;
        rdata_next    = rdata_reg;
        irq_next      = irq_en_reg && (status_reg != 3'd0);

        if (wr_delay) begin
            if (avs_writedata < MIN_W)
                delay_next = MIN_D;
            else if (avs_writedata > MAX_W)
                delay_next = MAX_D;
            else
                delay_next = avs_writedata[DELAY_WIDTH-1:0];
        end else if (acc_slow && (delay_reg != MAX_D)) begin
            delay_next = delay_reg + 1'b1;
        end else if (acc_fast && (delay_reg != MIN_D)) begin
            delay_next = delay_reg - 1'b1;
        end

        if (wr_ctrl) begin
            key_en_next = avs_writedata[0];
            irq_en_next = avs_writedata[1];
        end

        // Clear first so a same-cycle set event wins.
        if (wr_status)
            status_next = status_reg & ~avs_writedata[2:0];
        if (acc_slow && (delay_reg == MAX_D))
            status_next[0] = 1'b1;
        if (acc_fast && (delay_reg == MIN_D))
            status_next[1] = 1'b1;
        if (key_drop)
            status_next[2] = 1'b1;

        if (acc_slow && (slow_cnt_next != 16'hFFFF))
            slow_cnt_next = slow_cnt_next + 16'd1;
        if (acc_fast && (fast_cnt_next != 16'hFFFF))
            fast_cnt_next = fast_cnt_next + 16'd1;

        if (acc_slow || acc_fast)
            hold_next = HOLD_LOAD;
        else if (hold_reg != '0)
            hold_next = hold_reg - 1'b1;

        if (avs_read) begin
            case (avs_address)
                2'd0:    rdata_next = 32'(delay_reg);
                2'd1:    rdata_next = {30'd0, irq_en_reg, key_en_reg};
                2'd2:    rdata_next = {29'd0, status_reg};
                default: rdata_next = {fast_cnt_reg, slow_cnt_reg};
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            delay_reg    <= DEF_D;
            key_en_reg   <= 1'b1;
            irq_en_reg   <= 1'b0;
            status_reg   <= 3'd0;
            slow_cnt_reg <= 16'd0;
            fast_cnt_reg <= 16'd0;
            hold_reg     <= '0;
            rdata_reg    <= 32'd0;
            irq_reg      <= 1'b0;
        end else begin
            delay_reg    <= delay_next;
            key_en_reg   <= key_en_next;
            irq_en_reg   <= irq_en_next;
            status_reg   <= status_next;
            slow_cnt_reg <= slow_cnt_next;
            fast_cnt_reg <= fast_cnt_next;
            hold_reg     <= hold_next;
            rdata_reg    <= rdata_next;
            irq_reg      <= irq_next;
        end
    end

    assign delay        = delay_reg;
    assign avs_readdata = rdata_reg;
    assign irq          = irq_reg;

endmodule
